video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing source: generates the i_vs/i_hs sync stream that filter_fsm consumes, plus
//  o_de and active-pixel coordinates for the pattern/frame source. Frame = VSY+VBP+VAC+VFP
//  lines; line = HSY+HBP+HAC+HFP clocks. Starts on i_en and stops cleanly at frame boundaries.
// PARAMETERS
//  CNT_H_SIZE 12    width of horizontal counter / o_x
//  CNT_V_SIZE 12    width of vertical counter / o_y
//  HSY 1 | HBP 3 | HAC 1920 | HFP 3    line segments in clocks, each >=1
//  VSY 3 | VBP 3 | VAC 1080 | VFP 3    frame segments in lines, each >=1
// PORTS
//  clk           in   1           clock
//  rst           in   1           synchronous reset, active-high
//  i_en          in   1           run request; sampled at frame boundaries only
//  o_vs          out  1           vertical sync
//  o_hs          out  1           horizontal sync
//  o_de          out  1           active pixel
//  o_x           out  CNT_H_SIZE  active column 0..HAC-1; 0 when !o_de
//  o_y           out  CNT_V_SIZE  active row 0..VAC-1; 0 when !o_de
//  o_frame_start out  1           1-cycle pulse on cycle 0 of line 0
//  o_busy        out  1           frame in progress
//  o_frame_cnt   out  8           completed-frame count, wraps 255->0
// BEHAVIOUR
//  - All outputs registered. rst=1: every output 0, both FSMs IDLE, counters 0.
//  - H FSM (one-hot): H_IDLE,H_SYNC,H_BP,H_ACT,H_FP; h_cnt 0..HTOT-1 (HTOT=HSY+HBP+HAC+HFP).
//    SYNC h_cnt<HSY; BP <HSY+HBP; ACT <HSY+HBP+HAC; FP to HTOT-1; wrap to 0 (SYNC).
//  - V FSM (one-hot): V_IDLE,V_SYNC,V_BP,V_ACT,V_FP; v_cnt 0..VTOT-1, advances only on the
//    last clock of a line (h_cnt==HTOT-1). Segments bounded as H, in lines.
//  - Start: IDLE and i_en=1 at edge N -> edge N+1 outputs h_cnt=0,v_cnt=0: o_hs=1, o_vs=1,
//    o_frame_start=1, o_busy=1. Exactly one clock latency.
//  - o_hs=1 while H_SYNC (every line incl. blanking lines). o_vs=1 for all clocks of lines in V_SYNC.
//  - o_de = H_ACT & V_ACT; o_x=h_cnt-(HSY+HBP), o_y=v_cnt-(VSY+VBP), both valid with o_de.
//  - Frame end (h_cnt==HTOT-1 & v_cnt==VTOT-1): o_frame_cnt+1 (mod 256);
//    i_en=1 -> next clock is line 0 (back-to-back frames, no gap, o_frame_start again);
//    i_en=0 -> next clock both FSMs IDLE, o_busy=0, syncs/de 0, counters 0.
//  - i_en changes mid-frame ignored; current frame always completes.
//  - rst mid-frame: outputs 0 next clock, no partial-frame count; restart needs i_en.
//  - Illegal one-hot state -> IDLE (default branch).
//  - Counter widths must hold HTOT-1/VTOT-1; no overflow detection required.
// TESTING  (small config: HSY1 HBP2 HAC4 HFP1 -> HTOT8; VSY1 VBP1 VAC2 VFP1 -> VTOT5; 40 clk/frame)
//  1 rst held, i_en toggled -> all outputs 0, o_busy 0 throughout.
//  2 i_en=1 at edge N -> edge N+1 o_vs=o_hs=o_frame_start=1; o_hs high 1 clk every 8 clks;
//    o_vs high clks N+1..N+8.
//  3 Active window: o_de high at line 2 h_cnt 3..6 with o_x=0,1,2,3 o_y=0, line 3 o_y=1;
//    exactly 8 de clocks per frame.
//  4 i_en held 1 for 3 frames -> o_frame_start every 40 clks, no gap; o_frame_cnt 1,2,3.
//  5 i_en dropped mid-frame 1 -> frame finishes; clock after frame end o_busy=0; o_frame_cnt=1.
//  6 rst pulsed during line 3 -> next clk all 0; re-enable starts at line 0; o_frame_cnt=0;
//    preload 255 frames -> wraps to 0.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing source: H/V one-hot FSMs walk a frame of lines and emit registered
// sync, data-enable, active coordinates, frame-start pulse, busy flag and frame count.
module video_timing_gen #(
   parameter int CNT_H_SIZE = 12,
   parameter int CNT_V_SIZE = 12,
   parameter int HSY        = 1,
   parameter int HBP        = 3,
   parameter int HAC        = 1920,
   parameter int HFP        = 3,
   parameter int VSY        = 3,
   parameter int VBP        = 3,
   parameter int VAC        = 1080,
   parameter int VFP        = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_en,
   output logic                  o_vs,
   output logic                  o_hs,
   output logic                  o_de,
   output logic [CNT_H_SIZE-1:0] o_x,
   output logic [CNT_V_SIZE-1:0] o_y,
   output logic                  o_frame_start,
   output logic                  o_busy,
   output logic [7:0]            o_frame_cnt
);

   localparam int HTOT = HSY + HBP + HAC + HFP;
   localparam int VTOT = VSY + VBP + VAC + VFP;

   localparam logic [CNT_H_SIZE-1:0] H_BP0  = CNT_H_SIZE'(HSY);
   localparam logic [CNT_H_SIZE-1:0] H_ACT0 = CNT_H_SIZE'(HSY + HBP);
   localparam logic [CNT_H_SIZE-1:0] H_FP0  = CNT_H_SIZE'(HSY + HBP + HAC);
   localparam logic [CNT_H_SIZE-1:0] H_LAST = CNT_H_SIZE'(HTOT - 1);
   localparam logic [CNT_V_SIZE-1:0] V_BP0  = CNT_V_SIZE'(VSY);
   localparam logic [CNT_V_SIZE-1:0] V_ACT0 = CNT_V_SIZE'(VSY + VBP);
   localparam logic [CNT_V_SIZE-1:0] V_FP0  = CNT_V_SIZE'(VSY + VBP + VAC);
   localparam logic [CNT_V_SIZE-1:0] V_LAST = CNT_V_SIZE'(VTOT - 1);

   typedef enum logic [4:0] {
      H_IDLE = 5'b00001, H_SYNC = 5'b00010, H_BP = 5'b00100, H_ACT = 5'b01000, H_FP = 5'b10000
   } h_state_t;
   typedef enum logic [4:0] {
      V_IDLE = 5'b00001, V_SYNC = 5'b00010, V_BP = 5'b00100, V_ACT = 5'b01000, V_FP = 5'b10000
   } v_state_t;

   function automatic h_state_t h_seg(input logic [CNT_H_SIZE-1:0] c);
      if (c < H_BP0)       return H_SYNC;
      else if (c < H_ACT0) return H_BP;
      else if (c < H_FP0)  return H_ACT;
      else                 return H_FP;
   endfunction

   function automatic v_state_t v_seg(input logic [CNT_V_SIZE-1:0] c);
      if (c < V_BP0)       return V_SYNC;
      else if (c < V_ACT0) return V_BP;
      else if (c < V_FP0)  return V_ACT;
      else                 return V_FP;
   endfunction

   h_state_t              h_state_q, h_state_d;
   v_state_t              v_state_q, v_state_d;
   logic [CNT_H_SIZE-1:0] h_cnt_q, h_cnt_d, x_q, x_d;
   logic [CNT_V_SIZE-1:0] v_cnt_q, v_cnt_d, y_q, y_d;
   logic [7:0]            frame_cnt_q, frame_cnt_d;
   logic                  vs_q, vs_d, hs_q, hs_d, de_q, de_d;
   logic                  fs_q, fs_d, busy_q, busy_d;
   logic                  h_run, v_run, go;

   always_ff @(posedge clk) begin
      if (rst) begin
         h_state_q   <= H_IDLE;
         v_state_q   <= V_IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         frame_cnt_q <= '0;
         vs_q        <= 1'b0;
         hs_q        <= 1'b0;
         de_q        <= 1'b0;
         fs_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         h_state_q   <= h_state_d;
         v_state_q   <= v_state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         frame_cnt_q <= frame_cnt_d;
         vs_q        <= vs_d;
         hs_q        <= hs_d;
         de_q        <= de_d;
         fs_q        <= fs_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      h_state_d   = H_IDLE;
      v_state_d   = V_IDLE;
      frame_cnt_d = frame_cnt_q;
      go          = 1'b0;

      // Illegal one-hot encodings fall to the default and are treated as not running.
      case (h_state_q)
         H_SYNC, H_BP, H_ACT, H_FP: h_run = 1'b1;
         default:                   h_run = 1'b0;
      endcase
      case (v_state_q)
         V_SYNC, V_BP, V_ACT, V_FP: v_run = 1'b1;
         default:                   v_run = 1'b0;
      endcase

      if (h_run && v_run) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
               // i_en only matters here, at the frame boundary.
               frame_cnt_d = frame_cnt_q + 8'd1;
               v_cnt_d     = '0;
               go          = i_en;
            end else begin
               v_cnt_d = v_cnt_q + 1'b1;
               go      = 1'b1;
            end
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
            go      = 1'b1;
         end
      end else if (h_state_q == H_IDLE && v_state_q == V_IDLE && i_en) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
         go      = 1'b1;
      end

      if (go) begin
         h_state_d = h_seg(h_cnt_d);
         v_state_d = v_seg(v_cnt_d);
      end else begin
         h_cnt_d = '0;
         v_cnt_d = '0;
      end

      // Outputs are decoded from the next state so they line up with it after the edge.
      hs_d   = (h_state_d == H_SYNC);
      vs_d   = (v_state_d == V_SYNC);
      de_d   = (h_state_d == H_ACT) && (v_state_d == V_ACT);
      x_d    = de_d ? h_cnt_d - H_ACT0 : '0;
      y_d    = de_d ? v_cnt_d - V_ACT0 : '0;
      fs_d   = go && (h_cnt_d == '0) && (v_cnt_d == '0);
      busy_d = go;
   end

   assign o_vs          = vs_q;
   assign o_hs          = hs_q;
   assign o_de          = de_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_frame_start = fs_q;
   assign o_busy        = busy_q;
   assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen (small raster): a frame-position model pushes the
// expected outputs per cycle; a monitor pops and compares after every clock edge.
module tb_video_timing_gen;

   localparam int HSY = 1, HBP = 2, HAC = 4, HFP = 1;
   localparam int VSY = 1, VBP = 1, VAC = 2, VFP = 1;
   localparam int HTOT = HSY + HBP + HAC + HFP;
   localparam int VTOT = VSY + VBP + VAC + VFP;
   localparam int FRAME = HTOT * VTOT;

   typedef struct packed {
      logic       vs, hs, de;
      logic [3:0] x, y;
      logic       fs, busy;
      logic [7:0] fc;
   } out_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_en = 1'b0;
   logic       o_vs, o_hs, o_de, o_frame_start, o_busy;
   logic [3:0] o_x, o_y;
   logic [7:0] o_frame_cnt;

   int   checks = 0;
   int   failures = 0;
   out_t q[$];

   // Reference model state: running flag, position within the frame, completed frames.
   bit   m_run = 0;
   int   m_pos = 0;
   int   m_fc = 0;

   video_timing_gen #(
      .CNT_H_SIZE(4), .CNT_V_SIZE(4),
      .HSY(HSY), .HBP(HBP), .HAC(HAC), .HFP(HFP),
      .VSY(VSY), .VBP(VBP), .VAC(VAC), .VFP(VFP)
   ) dut (
      .clk(clk), .rst(rst), .i_en(i_en),
      .o_vs(o_vs), .o_hs(o_hs), .o_de(o_de), .o_x(o_x), .o_y(o_y),
      .o_frame_start(o_frame_start), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic e);
      out_t exp;
      int   line, col;
      @(negedge clk);
      rst  = r;
      i_en = e;
      if (r) begin
         m_run = 0; m_pos = 0; m_fc = 0;
      end else if (!m_run) begin
         if (e) begin m_run = 1; m_pos = 0; end
      end else if (m_pos == FRAME - 1) begin
         m_fc  = (m_fc + 1) % 256;
         m_pos = 0;
         m_run = e;
      end else begin
         m_pos++;
      end
      exp    = '0;
      exp.fc = 8'(m_fc);
      if (m_run) begin
         line     = m_pos / HTOT;
         col      = m_pos % HTOT;
         exp.busy = 1'b1;
         exp.hs   = (col < HSY);
         exp.vs   = (line < VSY);
         exp.fs   = (m_pos == 0);
         exp.de   = (col >= HSY + HBP) && (col < HSY + HBP + HAC) &&
                    (line >= VSY + VBP) && (line < VSY + VBP + VAC);
         if (exp.de) begin
            exp.x = 4'(col - (HSY + HBP));
            exp.y = 4'(line - (VSY + VBP));
         end
      end
      q.push_back(exp);
   endtask

   always @(posedge clk) begin
      out_t e, a;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         a = '{o_vs, o_hs, o_de, o_x, o_y, o_frame_start, o_busy, o_frame_cnt};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL outputs t=%0t got vs%b hs%b de%b x%0d y%0d fs%b busy%b fc%0d want vs%b hs%b de%b x%0d y%0d fs%b busy%b fc%0d",
                     $time, a.vs, a.hs, a.de, a.x, a.y, a.fs, a.busy, a.fc,
                     e.vs, e.hs, e.de, e.x, e.y, e.fs, e.busy, e.fc);
         end
      end
   end

   initial begin
      // Reset held while i_en wiggles.
      for (int i = 0; i < 12; i++) drive(1'b1, 1'(($urandom & 1)));
      // Three back-to-back frames, then random i_en (ignored mid-frame).
      for (int i = 0; i < 3 * FRAME + 10; i++) drive(1'b0, 1'b1);
      for (int i = 0; i < 300; i++) drive(1'b0, 1'(($urandom & 1)));
      for (int i = 0; i < 2 * FRAME; i++) drive(1'b0, 1'b0);
      // One frame, drop i_en mid-frame, frame must still finish.
      drive(1'b0, 1'b1);
      for (int i = 0; i < 60; i++) drive(1'b0, 1'b0);
      // Reset pulsed during line 3, then restart.
      for (int i = 0; i < 3 * HTOT + 2; i++) drive(1'b0, 1'b1);
      drive(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0);
      // Long run to wrap the frame counter past 255.
      for (int i = 0; i < 257 * FRAME + 5; i++) drive(1'b0, 1'b1);
      // Random mix including occasional resets.
      for (int i = 0; i < 600; i++)
         drive(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < FRAME + 2; i++) drive(1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
